// File: rtl/present_key_schedule.sv
// PRESENT round-key generator: loads one master key, then streams
// K1..K_NUM_ROUNDS one per cycle under valid/ready backpressure.
module present_key_schedule #(
    parameter int KEY_SIZE   = 80,
    parameter int NUM_ROUNDS = 32,
    parameter int BLOCK_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [KEY_SIZE-1:0]   key_in,
    input  logic                  abort,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [BLOCK_SIZE-1:0] rk_data,
    output logic [4:0]            rk_idx,
    output logic                  rk_last
);

    if (!(KEY_SIZE == 80 || KEY_SIZE == 128)) begin : g_bad_key
        $error("KEY_SIZE must be 80 or 128");
    end
    if (NUM_ROUNDS < 2 || NUM_ROUNDS > 32) begin : g_bad_rounds
        $error("NUM_ROUNDS must be 2..32");
    end
    if (BLOCK_SIZE != 64) begin : g_bad_block
        $error("BLOCK_SIZE must be 64");
    end

    // Counter is 6 bits so the final index 32 is representable.
    localparam logic [5:0] LAST = 6'(NUM_ROUNDS);
    localparam int         XLO  = (KEY_SIZE == 128) ? 62 : 15;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [KEY_SIZE-1:0] key_reg;
    logic [5:0]          round;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
        endcase
        return y;
    endfunction

    // One key-register step: rotate left 61, S-box top nibble(s),
    // then fold in the index of the key being retired.
    function automatic logic [KEY_SIZE-1:0] upd(
        input logic [KEY_SIZE-1:0] k,
        input logic [4:0]          r
    );
        logic [KEY_SIZE-1:0] t;
        t = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
        t[KEY_SIZE-1 -: 4] = sbox(t[KEY_SIZE-1 -: 4]);
        if (KEY_SIZE == 128) begin
            t[KEY_SIZE-5 -: 4] = sbox(t[KEY_SIZE-5 -: 4]);
        end
        t[XLO +: 5] = t[XLO +: 5] ^ r;
        return t;
    endfunction

    assign rk_data = key_reg[KEY_SIZE-1 -: BLOCK_SIZE];
    assign rk_idx  = round[4:0];

    // Load/stream control with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_reg   <= '0;
            round     <= 6'd1;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!abort && key_valid) begin
                        key_reg   <= key_in;
                        round     <= 6'd1;
                        state     <= RUN;
                        key_ready <= 1'b0;
                        rk_valid  <= 1'b1;
                        rk_last   <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort || (rk_ready && round == LAST)) begin
                        state     <= IDLE;
                        key_ready <= 1'b1;
                        rk_valid  <= 1'b0;
                        rk_last   <= 1'b0;
                    end else if (rk_ready) begin
                        key_reg <= upd(key_reg, round[4:0]);
                        round   <= round + 6'd1;
                        rk_last <= (round + 6'd1 == LAST);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_key_schedule.sv
// Bench for present_key_schedule: 80- and 128-bit instances in
// lock-step, checked against a plain-arithmetic key-schedule model.
module tb_present_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b0;
    logic [79:0]  key_in80 = '0;
    logic [127:0] key_in128 = '0;

    logic        key_ready80, rk_valid80, rk_last80;
    logic [63:0] rk_data80;
    logic [4:0]  rk_idx80;
    logic        key_ready128, rk_valid128, rk_last128;
    logic [63:0] rk_data128;
    logic [4:0]  rk_idx128;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_k [1:32];
    logic [63:0] cap [1:32];
    logic [3:0]  sb [16];

    present_key_schedule #(.KEY_SIZE(80)) dut80 (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready80),
        .key_in(key_in80), .abort(abort),
        .rk_valid(rk_valid80), .rk_ready(rk_ready),
        .rk_data(rk_data80), .rk_idx(rk_idx80),
        .rk_last(rk_last80)
    );

    present_key_schedule #(.KEY_SIZE(128)) dut128 (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready128),
        .key_in(key_in128), .abort(abort),
        .rk_valid(rk_valid128), .rk_ready(rk_ready),
        .rk_data(rk_data128), .rk_idx(rk_idx128),
        .rk_last(rk_last128)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference key schedule built from shifts and masks.
    task automatic model(input logic [127:0] key, input bit w128);
        int n;
        logic [127:0] k, mask;
        logic [3:0] hi;
        n = w128 ? 128 : 80;
        mask = w128 ? {128{1'b1}} : ((128'd1 << 80) - 128'd1);
        k = key & mask;
        for (int i = 1; i <= 32; i++) begin
            exp_k[i] = 64'(k >> (n - 64));
            k = ((k << 61) | (k >> (n - 61))) & mask;
            hi = 4'(k >> (n - 4));
            k = (k & ~(128'hF << (n - 4))) | (128'(sb[hi]) << (n - 4));
            if (w128) begin
                hi = 4'(k >> (n - 8));
                k = (k & ~(128'hF << (n - 8))) | (128'(sb[hi]) << (n - 8));
            end
            k = k ^ (128'(i & 31) << (w128 ? 62 : 15));
        end
    endtask

    task automatic load(input logic [127:0] k);
        key_in80  = k[79:0];
        key_in128 = k;
        key_valid = 1'b1;
        chk("key_ready80_idle", 64'(key_ready80), 64'd1);
        chk("key_ready128_idle", 64'(key_ready128), 64'd1);
        @(negedge clk);
        key_valid = 1'b0;
        key_in80  = {$urandom, $urandom, $urandom};
        key_in128 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // mode 0: full stream, 1: abort at idx, 2: reset at idx
    task automatic stream(input bit w128, input bit rnd, input int mode,
                          input int at, input logic [127:0] rkey);
        int idx;
        int cyc;
        logic [63:0] d;
        idx = 1;
        cyc = 0;
        while (idx <= 32) begin
            if (cyc > 400) begin
                chk("stream_timeout", 64'(idx), 64'd33);
                break;
            end
            d = w128 ? rk_data128 : rk_data80;
            cap[idx] = d;
            chk("rk_valid", 64'(w128 ? rk_valid128 : rk_valid80), 64'd1);
            chk("key_ready_run", 64'(w128 ? key_ready128 : key_ready80), 64'd0);
            chk("rk_idx", 64'(w128 ? rk_idx128 : rk_idx80), 64'(idx[4:0]));
            chk("rk_last", 64'(w128 ? rk_last128 : rk_last80), 64'(idx == 32));
            chk("rk_data", d, exp_k[idx]);
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 1 && idx == at) begin
                abort = 1'b1;
                rk_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                rk_ready = 1'b0;
                chk("abort_valid", 64'(rk_valid80), 64'd0);
                chk("abort_key_ready", 64'(key_ready80), 64'd1);
                chk("abort_last", 64'(rk_last80), 64'd0);
                return;
            end
            if (mode == 2 && idx == at) begin
                rst_n = 1'b0;
                key_valid = 1'b1;
                key_in80 = rkey[79:0];
                key_in128 = rkey;
                @(negedge clk);
                rk_ready = 1'b0;
                chk("rst_key_ready", 64'(key_ready80), 64'd1);
                chk("rst_valid", 64'(rk_valid80), 64'd0);
                chk("rst_data", rk_data80, 64'd0);
                chk("rst_idx", 64'(rk_idx80), 64'd1);
                chk("rst_last", 64'(rk_last80), 64'd0);
                return;
            end
            if (rk_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        rk_ready = 1'b0;
        chk("end_valid", 64'(w128 ? rk_valid128 : rk_valid80), 64'd0);
        chk("end_key_ready", 64'(w128 ? key_ready128 : key_ready80), 64'd1);
        chk("end_last", 64'(w128 ? rk_last128 : rk_last80), 64'd0);
    endtask

    // PRESENT-80 encryption of a block with the captured key stream.
    task automatic encrypt_check(input logic [63:0] pt, input logic [63:0] ct);
        logic [63:0] s, t;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ cap[r];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = sb[s[4*j +: 4]];
            t = '0;
            for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (j * 16) % 63] = s[j];
            s = t;
        end
        s = s ^ cap[32];
        chk("ciphertext", s, ct);
    endtask

    initial begin
        logic [127:0] k, k2;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

        repeat (2) @(negedge clk);
        chk("reset_key_ready", 64'(key_ready80), 64'd1);
        chk("reset_valid", 64'(rk_valid80), 64'd0);
        chk("reset_data", rk_data80, 64'd0);
        chk("reset_idx", 64'(rk_idx80), 64'd1);
        chk("reset_last", 64'(rk_last80), 64'd0);
        chk("reset_valid128", 64'(rk_valid128), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort beats key_valid in IDLE
        abort = 1'b1;
        key_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        key_valid = 1'b0;
        chk("idle_abort_valid", 64'(rk_valid80), 64'd0);
        chk("idle_abort_ready", 64'(key_ready80), 64'd1);

        // T1: zero key, 80-bit, full throughput
        model(128'd0, 1'b0);
        load(128'd0);
        stream(1'b0, 1'b0, 0, 0, 128'd0);
        chk("t1_k1", cap[1], 64'h0000_0000_0000_0000);
        chk("t1_k2", cap[2], 64'hC000_0000_0000_0000);
        encrypt_check(64'd0, 64'h5579_C138_7B22_8445);

        // T2: all-ones key
        k = {128{1'b1}};
        model(k, 1'b0);
        load(k);
        stream(1'b0, 1'b0, 0, 0, 128'd0);
        chk("t2_k1", cap[1], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_k2", cap[2], 64'h2FFF_FFFF_FFFF_FFFF);

        // T3: zero key, 128-bit
        model(128'd0, 1'b1);
        load(128'd0);
        stream(1'b1, 1'b0, 0, 0, 128'd0);
        chk("t3_k1", cap[1], 64'd0);
        chk("t3_k2", cap[2], 64'hCC00_0000_0000_0000);

        // T4: random backpressure on zero key
        model(128'd0, 1'b0);
        load(128'd0);
        stream(1'b0, 1'b1, 0, 0, 128'd0);

        // random keys, both widths, with and without stalls
        for (int it = 0; it < 4; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model(k, it[0]);
            load(k);
            stream(it[0], it[1], 0, 0, 128'd0);
        end

        // T5: abort at idx 7, then reload
        k = {$urandom, $urandom, $urandom, $urandom};
        model(k, 1'b0);
        load(k);
        stream(1'b0, 1'b0, 1, 7, 128'd0);
        load(k);
        stream(1'b0, 1'b0, 0, 0, 128'd0);

        // T6: reset at idx 12 with key_valid held
        k2 = {$urandom, $urandom, $urandom, $urandom};
        model(k, 1'b0);
        load(k);
        stream(1'b0, 1'b1, 2, 12, k2);
        model(k2, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        stream(1'b0, 1'b0, 0, 0, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
